dmem_pipelined: RTL

// - Parametrised single-port data memory for the in-order core; replaces the fixed 64-word

---
 rtl/dmem_pipelined.sv | 114 +++++++++++
 1 files changed

// File: rtl/dmem_pipelined.sv
// Single-port data memory with valid/ready requests, byte-enable writes, RD_LAT-deep read pipeline
// and a post-reset zeroing sweep. Define DMEM_PARITY_EN to add per-byte even parity (rsp_perr/perr_inj).
module dmem_pipelined #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
`ifdef DMEM_PARITY_EN
    output logic                  rsp_perr,
    input  logic                  perr_inj,
`endif
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  busy
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    function automatic logic [NB-1:0] calc_par(input logic [DATA_W-1:0] w);
        logic [NB-1:0] p;
        for (int i = 0; i < NB; i++) p[i] = ^w[i*8 +: 8];
        return p;
    endfunction

    logic [0:0]        state;
    logic [ADDR_W-1:0] init_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_acc;
    logic              rd_acc;
    logic [RD_LAT-1:0] vld_p;
    logic [DATA_W-1:0] data_p [RD_LAT];

    // Gating with reset keeps all handshake outputs quiet during the reset cycle itself.
    assign req_ready = (state == ST_READY) & ~reset;
    assign wr_acc    = req_valid & req_ready & req_we;
    assign rd_acc    = req_valid & req_ready & ~req_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_INIT;
            init_ptr <= '0;
        end else if (state == ST_INIT) begin
            init_ptr <= init_ptr + 1'b1;
            if (init_ptr == LAST_ADDR) state <= ST_READY;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && state == ST_INIT) begin
            mem[init_ptr] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NB; i++)
                if (req_be[i]) mem[req_addr][i*8 +: 8] <= req_wdata[i*8 +: 8];
        end
    end

    // Stage 0 samples the array at the accept edge; later stages only shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= rd_acc;
            for (int s = 1; s < RD_LAT; s++) vld_p[s] <= vld_p[s-1];
        end
    end

    always_ff @(posedge clk) begin
        data_p[0] <= mem[req_addr];
        for (int s = 1; s < RD_LAT; s++) data_p[s] <= data_p[s-1];
    end

    assign rsp_valid = vld_p[RD_LAT-1] & ~reset;
    assign rsp_rdata = rsp_valid ? data_p[RD_LAT-1] : '0;
    assign busy      = reset | (state == ST_INIT) | (|vld_p);

`ifdef DMEM_PARITY_EN
    logic [NB-1:0] mem_par [DEPTH];
    logic [NB-1:0] par_p   [RD_LAT];
    logic [NB-1:0] wpar;

    assign wpar = calc_par(req_wdata) ^ {NB{perr_inj}};

    always_ff @(posedge clk) begin
        if (!reset && state == ST_INIT) begin
            mem_par[init_ptr] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NB; i++)
                if (req_be[i]) mem_par[req_addr][i] <= wpar[i];
        end
    end

    always_ff @(posedge clk) begin
        par_p[0] <= mem_par[req_addr];
        for (int s = 1; s < RD_LAT; s++) par_p[s] <= par_p[s-1];
    end

    assign rsp_perr = rsp_valid & (|(par_p[RD_LAT-1] ^ calc_par(data_p[RD_LAT-1])));
`endif

endmodule
